// File: rtl/aes256_inv_cipher.sv
// aes256_inv_cipher: iterative AES-256 decryption core (inverse cipher).
// One inverse round per clock. The round keys are expanded into a local
// round-key file, one 4-word round key per clock, and are reused without
// re-expansion when the next block arrives with the same key (KEY_CACHE=1).
//
// Ports:
//   clk        - system clock, all state on the rising edge
//   reset      - asynchronous active-high reset, clears all state and the key cache
//   start      - request, sampled only while busy=0
//   ciphertext - 128-bit input block, byte 0 in bits [127:120]
//   key        - 256-bit cipher key, byte 0 in bits [255:248]
//   plaintext  - decrypted block, valid while done=1, held until the next result
//   done       - high from completion until the next accepted start or reset
//   busy       - high while an operation is in progress
module aes256_inv_cipher #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [255:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ARK0, S_ROUND, S_FINAL} state_t;

  // GF(2^8) multiply, modulus x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int k = 7; k >= 0; k--) begin
      r = gf_mul(r, r);
      if (e[k]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-boxes computed from their algebraic definition instead of tables
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  state_t        r_state, w_state_next;
  logic [127:0]  r_blk;          // working state; holds the ciphertext right after accept
  logic [127:0]  r_plaintext;
  logic          r_done;
  logic [3:0]    r_cnt;          // KEXP: round key index 2..14; ARK0/ROUND/FINAL: round key in use
  logic [255:0]  r_kw;           // last 8 expanded words, feeds the next round key
  logic [255:0]  r_cache_key;
  logic          r_cache_valid;
  logic [127:0]  r_rk [0:15];    // round-key file, entry 15 unused

  logic          w_accept, w_hit;
  logic [127:0]  w_rk, w_isb, w_ark, w_imc, w_rk_new;
  logic [31:0]   w_temp, w_nw0, w_nw1, w_nw2, w_nw3;
  logic [7:0]    w_rcon;

  // ARK0, ROUND and FINAL all read the round key selected by r_cnt
  assign w_rk = r_rk[r_cnt];

  // InvShiftRows followed by InvSubBytes: out[row,col] = inv_sbox(in[row, col-row])
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_isb
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
      assign w_isb[127-8*gi -: 8] = inv_sbox(r_blk[127-8*SRC -: 8]);
    end
  endgenerate

  assign w_ark = w_isb ^ w_rk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_imc
      assign w_imc[127-32*gi -: 32] = inv_mix_col(w_ark[127-32*gi -: 32]);
    end
  endgenerate

  // One round key per edge: even index uses RotWord+Rcon, odd index SubWord only
  always_comb begin
    w_rcon = 8'h01 << (r_cnt[3:1] - 3'd1);
    w_temp = 32'h0;
    if (!r_cnt[0]) begin
      w_temp = sub_word({r_kw[23:0], r_kw[31:24]}) ^ {w_rcon, 24'h000000};
    end else begin
      w_temp = sub_word(r_kw[31:0]);
    end
    w_nw0    = r_kw[255:224] ^ w_temp;
    w_nw1    = r_kw[223:192] ^ w_nw0;
    w_nw2    = r_kw[191:160] ^ w_nw1;
    w_nw3    = r_kw[159:128] ^ w_nw2;
    w_rk_new = {w_nw0, w_nw1, w_nw2, w_nw3};
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_hit ? S_ARK0 : S_KEXP;
      S_KEXP:  if (r_cnt == 4'd14) w_state_next = S_ARK0;
      S_ARK0:  w_state_next = S_ROUND;
      S_ROUND: if (r_cnt == 4'd1) w_state_next = S_FINAL;
      S_FINAL: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs and control strobes
  always_comb begin
    busy     = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && start;
    w_hit    = (KEY_CACHE != 0) && r_cache_valid && (key == r_cache_key);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blk         <= '0;
      r_plaintext   <= '0;
      r_done        <= 1'b0;
      r_cnt         <= '0;
      r_kw          <= '0;
      r_cache_key   <= '0;
      r_cache_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_blk  <= ciphertext;
          r_done <= 1'b0;
          r_kw   <= key;
          if (w_hit) begin
            r_cnt <= 4'd14;
          end else begin
            // Cache stays invalid until the expansion has completed
            r_cnt         <= 4'd2;
            r_cache_key   <= key;
            r_cache_valid <= 1'b0;
          end
        end
        S_KEXP: begin
          r_kw <= {r_kw[127:0], w_rk_new};
          if (r_cnt == 4'd14) r_cache_valid <= 1'b1;
          else                r_cnt         <= r_cnt + 4'd1;
        end
        S_ARK0: begin
          r_blk <= r_blk ^ w_rk;
          r_cnt <= r_cnt - 4'd1;
        end
        S_ROUND: begin
          r_blk <= w_imc;
          r_cnt <= r_cnt - 4'd1;
        end
        S_FINAL: begin
          r_plaintext <= w_ark;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Round-key file: contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (w_accept && !w_hit) begin
      r_rk[0] <= key[255:128];
      r_rk[1] <= key[127:0];
    end else if (r_state == S_KEXP) begin
      r_rk[r_cnt] <= w_rk_new;
    end
  end

  assign plaintext = r_plaintext;
  assign done      = r_done;

endmodule

// File: tb/tb_aes256_inv_cipher.sv
// Testbench for aes256_inv_cipher: known-answer vectors, key-cache latency,
// ignored start while busy, asynchronous reset, back-to-back start, and a
// set of random blocks encrypted by a reference forward cipher.
module tb_aes256_inv_cipher;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_c = 1'b0;
  logic         start_n = 1'b0;
  logic [127:0] ct = '0;
  logic [255:0] key = '0;
  logic [127:0] pt_c, pt_n;
  logic         done_c, done_n, busy_c, busy_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes256_inv_cipher #(.KEY_CACHE(1)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .ciphertext(ct), .key(key),
    .plaintext(pt_c), .done(done_c), .busy(busy_c)
  );

  aes256_inv_cipher #(.KEY_CACHE(0)) u_n (
    .clk(clk), .reset(reset), .start(start_n), .ciphertext(ct), .key(key),
    .plaintext(pt_n), .done(done_n), .busy(busy_n)
  );

  // Forward S-box table for the reference encryptor
  logic [0:255][7:0] sbox_t = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Reference AES-256 forward cipher
  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [255:0] k);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] blk;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = sw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    blk = p ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 14; r++) begin
      for (int n = 0; n < 16; n++) s[n] = blk[127-8*n -: 8];
      for (int n = 0; n < 16; n++) u[n] = sbox_t[s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (r < 14) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int n = 0; n < 16; n++) blk[127-8*n -: 8] = s[n];
      blk = blk ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return blk;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t q_c[$];
  exp_t q_n[$];
  logic done_c_d = 1'b0;
  logic done_n_d = 1'b0;

  // Monitor: every rising done pops one expectation from its scoreboard queue
  always @(negedge clk) begin
    if (done_c && !done_c_d) begin
      if (q_c.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done cache: plaintext %h with nothing outstanding", pt_c);
      end else begin
        exp_t e;
        e = q_c.pop_front();
        chk({e.name, " plaintext"}, pt_c, e.pt);
        chk_int({e.name, " latency"}, cyc - e.acc, e.lat);
        $display("txn %s: pt=%h latency=%0d", e.name, pt_c, cyc - e.acc);
      end
    end
    if (done_n && !done_n_d) begin
      if (q_n.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done nocache: plaintext %h with nothing outstanding", pt_n);
      end else begin
        exp_t e;
        e = q_n.pop_front();
        chk({e.name, " plaintext"}, pt_n, e.pt);
        chk_int({e.name, " latency"}, cyc - e.acc, e.lat);
        $display("txn %s: pt=%h latency=%0d", e.name, pt_n, cyc - e.acc);
      end
    end
    done_c_d <= done_c;
    done_n_d <= done_n;
  end

  task automatic push_exp(input bit which, input string name, input logic [127:0] p, input int lat);
    exp_t e;
    e.pt = p; e.lat = lat; e.acc = cyc; e.name = name;
    if (which) q_n.push_back(e);
    else       q_c.push_back(e);
  endtask

  // Present one request for a single cycle; the accepting edge is E0
  task automatic issue(input bit which, input string name, input logic [127:0] c,
                       input logic [255:0] k, input logic [127:0] p, input int lat, input bit push);
    @(negedge clk);
    ct = c; key = k;
    if (which) start_n = 1'b1; else start_c = 1'b1;
    @(posedge clk); #1;
    chk_int({name, " accepted"}, int'(which ? busy_n : busy_c), 1);
    if (push) push_exp(which, name, p, lat);
    @(negedge clk);
    start_n = 1'b0; start_c = 1'b0;
  endtask

  task automatic drain(input bit which, input string name);
    int n;
    n = 0;
    while ((which ? q_n.size() : q_c.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((which ? q_n.size() : q_c.size()) != 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within 100 cycles", name);
      if (which) q_n.delete(); else q_c.delete();
    end
  endtask

  localparam logic [255:0] K_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_FIPS = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K_SP   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C_SP1  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P_SP1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_SP2  = 128'h591ccb10d410ed26dc5ba74a31362870;
  localparam logic [127:0] P_SP2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rk;
    logic [127:0] rp;
    int           n;

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset plaintext", pt_c, '0);
    chk_int("reset done", int'(done_c), 0);
    chk_int("reset busy", int'(busy_c), 0);
    reset = 1'b0;

    // Known answers and cache behaviour
    issue(0, "fips_c3", C_FIPS, K_FIPS, P_FIPS, 28, 1);   drain(0, "fips_c3");
    issue(0, "sp_b1_miss", C_SP1, K_SP, P_SP1, 28, 1);    drain(0, "sp_b1_miss");
    issue(0, "sp_b2_hit", C_SP2, K_SP, P_SP2, 15, 1);     drain(0, "sp_b2_hit");
    issue(0, "fips_keychange", C_FIPS, K_FIPS, P_FIPS, 28, 1); drain(0, "fips_keychange");

    // Start pulse while busy must be ignored
    issue(0, "busy_first", C_SP1, K_SP, P_SP1, 28, 1);
    repeat (4) @(negedge clk);
    ct = C_FIPS; key = K_FIPS; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    drain(0, "busy_first");
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-operation
    issue(0, "reset_victim", C_SP2, K_SP, P_SP2, 15, 0);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset plaintext", pt_c, '0);
    chk_int("async reset done", int'(done_c), 0);
    chk_int("async reset busy", int'(busy_c), 0);
    @(negedge clk);
    reset = 1'b0;
    issue(0, "sp_b2_after_reset", C_SP2, K_SP, P_SP2, 28, 1); drain(0, "sp_b2_after_reset");

    // start held high: re-accepted on the edge after done rises
    @(negedge clk);
    ct = C_SP1; key = K_SP; start_c = 1'b1;
    @(posedge clk); #1;
    chk_int("hold_first accepted", int'(busy_c), 1);
    push_exp(0, "hold_first", P_SP1, 15);
    @(negedge clk);
    ct = C_SP2;
    n = 0;
    while (!done_c && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_int("hold done seen", int'(done_c), 1);
    @(posedge clk); #1;
    chk_int("hold reaccept busy", int'(busy_c), 1);
    chk_int("hold done one cycle", int'(done_c), 0);
    push_exp(0, "hold_second", P_SP2, 15);
    @(negedge clk);
    start_c = 1'b0;
    drain(0, "hold_second");

    // No key cache: repeated key still expands
    issue(1, "nc_b1", C_SP1, K_SP, P_SP1, 28, 1); drain(1, "nc_b1");
    issue(1, "nc_b2", C_SP2, K_SP, P_SP2, 28, 1); drain(1, "nc_b2");

    // Random blocks through the reference encryptor; every 4th reuses the key
    rk = '0;
    for (int i = 0; i < 100; i++) begin
      if (i % 4 != 3) rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      issue(0, $sformatf("rand%0d", i), aes_enc(rp, rk), rk, rp, (i % 4 == 3) ? 15 : 28, 1);
      drain(0, $sformatf("rand%0d", i));
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
